mac_arbiter: RTL
================

MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand width; result width is 2*DATA_WIDTH.
REQ-002 Parameter NREQ, 4, number of requesters sharing one mul instance.
REQ-003 Parameter LEN_W, 8, width of the per-requester pair-count field.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 req  in  NREQ  per-requester request, held until the result is accepted.
REQ-007 req_len  in  NREQ*LEN_W  packed pair count per requester, slice i = requester i.
REQ-008 s_tvalid  in  NREQ  per-requester operand-pair valid.
REQ-009 s_tready  out  NREQ  per-requester operand-pair ready.
REQ-010 s_tdata_a, s_tdata_b  in  NREQ*DATA_WIDTH each  packed signed operands.
REQ-011 gnt  out  NREQ  one-hot grant; all zero when idle.
REQ-012 mac_reset_n  out  1  drives the mul reset_n.
REQ-013 mac_tvalid  out  1  drives both mul tvalid inputs.
REQ-014 mac_a, mac_b  out  DATA_WIDTH each  drive the mul tdata inputs.
REQ-015 mac_tdata  in  2*DATA_WIDTH  mul m_axis_tdata.
REQ-016 mac_tvalid_in  in  1  mul m_axis_tvalid.
REQ-017 m_tdata  out  2*DATA_WIDTH  registered dot-product result.
REQ-018 m_tid  out  clog2(NREQ)  index of the requester owning m_tdata.
REQ-019 m_tvalid / m_tready  out / in  1 each  result handshake.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, STREAM, FLUSH, WAIT, OUT.
REQ-021 IDLE: if any req bit is high, the block SHALL select the winner round-robin, starting at (last_id+1) mod NREQ, latch id and req_len slice, set gnt, and go to CLEAR; otherwise it SHALL stay in IDLE.
REQ-022 CLEAR: the block SHALL drive mac_reset_n=0 for exactly one cycle, load beat counter=0, then go to STREAM, or go to FLUSH if the latched length is 0.
REQ-023 STREAM: the block SHALL drive s_tready[id]=1, with all other s_tready bits 0; a beat is s_tvalid[id]&&s_tready[id].
REQ-024 On a beat, the block SHALL drive mac_tvalid=1 and mac_a/mac_b = slice id of s_tdata_a/s_tdata_b, combinationally, and increment the counter; on a non-beat cycle, mac_tvalid SHALL be 0.
REQ-025 The beat with counter==len-1 SHALL move the FSM to FLUSH.
REQ-026 FLUSH: the block SHALL drive mac_tvalid=1 with mac_a=mac_b=0 for one cycle so the last product enters the sum, then go to WAIT.
REQ-027 WAIT: the block SHALL capture mac_tdata into m_tdata and id into m_tid when mac_tvalid_in=1, then go to OUT; mac_tvalid_in is 1 by construction.
REQ-028 OUT: the block SHALL hold m_tvalid=1 and m_tdata/m_tid stable until m_tready=1; on the handshake it SHALL update last_id=id, clear gnt, and return to IDLE.
REQ-029 m_tvalid SHALL assert on the cycle after WAIT. For len=N with s_tvalid held high, the latency from the grant cycle to m_tvalid is N+4 cycles.
REQ-030 Saturation SHALL be left to the mul; the arbiter passes mac_tdata unmodified.
REQ-031 Outside STREAM, s_tready SHALL be all zero; outside STREAM and FLUSH, mac_tvalid SHALL be 0 and mac_a/mac_b SHALL be 0.
REQ-032 mac_reset_n SHALL equal !(reset || state==CLEAR).
REQ-033 The block SHALL sample req only in IDLE; req changes during a transaction SHALL not affect the grant.
REQ-034 A requester that drops req mid-transaction SHALL still be served to completion.
REQ-035 Simultaneous requests SHALL be resolved only by the round-robin pointer; a requester SHALL wait at most NREQ-1 transactions.

Reset
REQ-036 While reset=1, the block SHALL force state=IDLE, gnt=0, s_tready=0, mac_tvalid=0, mac_a=mac_b=0, mac_reset_n=0, m_tvalid=0, m_tdata=0, m_tid=0, counter=0, and last_id=NREQ-1, so requester 0 wins first.
REQ-037 Reset asserted in any state SHALL abort the transaction on the next edge with no result emitted; the mul accumulator is cleared through mac_reset_n.

Verification
REQ-038 The bench SHALL cover: req[0], len=3, pairs (2,3)(4,5)(-1,6) with s_tvalid held high -> m_tvalid 7 cycles after the grant, m_tdata=20, m_tid=0.
REQ-039 The bench SHALL cover: req=4'b1111 held, each len=1 pair (1,1), m_tready=1 -> m_tid sequence 0,1,2,3,0.
REQ-040 The bench SHALL cover: len=2, s_tvalid gapped as 1,0,0,1 -> mac_tvalid low in the gap and m_tdata equal to the two-product sum.
REQ-041 The bench SHALL cover: len=0 -> m_tdata=0 and m_tvalid one cycle after WAIT.
REQ-042 The bench SHALL cover: DATA_WIDTH=32, two pairs of (0x7FFFFFFF,0x7FFFFFFF) plus enough further pairs to overflow -> m_tdata=0x7FFFFFFFFFFFFFFF, the mul saturation, passed unchanged.
REQ-043 The bench SHALL cover: reset pulsed during STREAM, then a new len=1 pair (3,3) -> no stale result, m_tdata=9.

Source files
------------

// File: rtl/mac_arbiter_if.sv
// mac_arbiter_if: bundles every non-clock signal of mac_arbiter.
//   Requester side : req, req_len, s_tvalid/s_tready, s_tdata_a/s_tdata_b, gnt
//   Multiplier side: mac_reset_n, mac_tvalid, mac_a/mac_b, mac_tdata, mac_tvalid_in
//   Result side    : m_tdata, m_tid, m_tvalid/m_tready
// Modport slave is the arbiter's view; modport master is the environment's view.
interface mac_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NREQ       = 4,
   parameter int unsigned LEN_W      = 8
);
   localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]            req;
   logic [NREQ*LEN_W-1:0]      req_len;
   logic [NREQ-1:0]            s_tvalid;
   logic [NREQ-1:0]            s_tready;
   logic [NREQ*DATA_WIDTH-1:0] s_tdata_a;
   logic [NREQ*DATA_WIDTH-1:0] s_tdata_b;
   logic [NREQ-1:0]            gnt;
   logic                       mac_reset_n;
   logic                       mac_tvalid;
   logic [DATA_WIDTH-1:0]      mac_a;
   logic [DATA_WIDTH-1:0]      mac_b;
   logic [2*DATA_WIDTH-1:0]    mac_tdata;
   logic                       mac_tvalid_in;
   logic [2*DATA_WIDTH-1:0]    m_tdata;
   logic [IdW-1:0]             m_tid;
   logic                       m_tvalid;
   logic                       m_tready;

   modport slave (
      input  req, req_len, s_tvalid, s_tdata_a, s_tdata_b, mac_tdata, mac_tvalid_in, m_tready,
      output s_tready, gnt, mac_reset_n, mac_tvalid, mac_a, mac_b, m_tdata, m_tid, m_tvalid
   );

   modport master (
      output req, req_len, s_tvalid, s_tdata_a, s_tdata_b, mac_tdata, mac_tvalid_in, m_tready,
      input  s_tready, gnt, mac_reset_n, mac_tvalid, mac_a, mac_b, m_tdata, m_tid, m_tvalid
   );
endinterface

// File: rtl/mac_arbiter.sv
// mac_arbiter: shares one accumulating multiplier among NREQ requesters. A round-robin winner
// streams req_len operand pairs into the multiplier; the resulting dot product is returned
// with the owner's index.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mac_arbiter_if.slave (requester, multiplier and result signals)
module mac_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NREQ       = 4,
   parameter int unsigned LEN_W      = 8
) (
   input logic          clk,
   input logic          reset,
   mac_arbiter_if.slave bus
);
   localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned RW  = 2 * DATA_WIDTH;

   typedef enum logic [2:0] {StIdle, StClear, StStream, StFlush, StWait, StOut} state_e;

   state_e                state_q, state_d;
   logic [IdW-1:0]        id_q, id_d;
   logic [IdW-1:0]        last_id_q, last_id_d;
   logic [IdW-1:0]        m_tid_q, m_tid_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [NREQ-1:0]       gnt_q, gnt_d;
   logic [RW-1:0]         m_tdata_q, m_tdata_d;

   logic [NREQ-1:0]       s_tready_c;
   logic                  mac_tvalid_c;
   logic [DATA_WIDTH-1:0] mac_a_c, mac_b_c;

   logic [LEN_W-1:0]      len_arr [NREQ];
   logic [DATA_WIDTH-1:0] a_arr   [NREQ];
   logic [DATA_WIDTH-1:0] b_arr   [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign len_arr[g] = bus.req_len[g*LEN_W +: LEN_W];
      assign a_arr[g]   = bus.s_tdata_a[g*DATA_WIDTH +: DATA_WIDTH];
      assign b_arr[g]   = bus.s_tdata_b[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin search starting one past the last served requester.
   logic           win_vld;
   logic [IdW-1:0] win_id;
   logic [IdW:0]   cand;

   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      cand    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = {1'b0, last_id_q} + (IdW+1)'(k);
         if (cand >= (IdW+1)'(NREQ)) cand = cand - (IdW+1)'(NREQ);
         if (!win_vld && bus.req[cand[IdW-1:0]]) begin
            win_vld = 1'b1;
            win_id  = cand[IdW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      gnt_d        = gnt_q;
      last_id_d    = last_id_q;
      m_tdata_d    = m_tdata_q;
      m_tid_d      = m_tid_q;
      s_tready_c   = '0;
      mac_tvalid_c = 1'b0;
      mac_a_c      = '0;
      mac_b_c      = '0;
      unique case (state_q)
         StIdle: begin
            if (win_vld) begin
               id_d    = win_id;
               len_d   = len_arr[win_id];
               gnt_d   = NREQ'(1) << win_id;
               state_d = StClear;
            end
         end
         StClear: begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? StFlush : StStream;
         end
         StStream: begin
            s_tready_c[id_q] = 1'b1;
            if (bus.s_tvalid[id_q]) begin
               mac_tvalid_c = 1'b1;
               mac_a_c      = a_arr[id_q];
               mac_b_c      = b_arr[id_q];
               cnt_d        = cnt_q + LEN_W'(1);
               if (cnt_q == len_q - LEN_W'(1)) state_d = StFlush;
            end
         end
         StFlush: begin
            // Zero-operand beat pushes the multiplier's last pending product into the sum.
            mac_tvalid_c = 1'b1;
            state_d      = StWait;
         end
         StWait: begin
            if (bus.mac_tvalid_in) begin
               m_tdata_d = bus.mac_tdata;
               m_tid_d   = id_q;
               state_d   = StOut;
            end
         end
         StOut: begin
            if (bus.m_tready) begin
               last_id_d = id_q;
               gnt_d     = '0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         id_q      <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         last_id_q <= IdW'(NREQ - 1);
         m_tdata_q <= '0;
         m_tid_q   <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         last_id_q <= last_id_d;
         m_tdata_q <= m_tdata_d;
         m_tid_q   <= m_tid_d;
      end
   end

   // Outputs are forced quiet for the whole reset cycle, not only after the edge.
   assign bus.s_tready    = reset ? '0 : s_tready_c;
   assign bus.mac_tvalid  = !reset && mac_tvalid_c;
   assign bus.mac_a       = reset ? '0 : mac_a_c;
   assign bus.mac_b       = reset ? '0 : mac_b_c;
   assign bus.mac_reset_n = !(reset || (state_q == StClear));
   assign bus.gnt         = reset ? '0 : gnt_q;
   assign bus.m_tvalid    = !reset && (state_q == StOut);
   assign bus.m_tdata     = reset ? '0 : m_tdata_q;
   assign bus.m_tid       = reset ? '0 : m_tid_q;
endmodule
